mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Unified program/data memory responder: zero-clears, accepts a program image, then serves the CPU.
// Optional write protection of the loaded image is enabled by defining MEM_WRITE_PROTECT_EN.
module mem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    input  logic [ADDR_W-1:0] programAddress,
    output logic [DATA_W-1:0] programData,
    input  logic [ADDR_W-1:0] address,
    input  logic              WE,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              prot_fault
);

    typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_load_count;
    logic [DATA_W-1:0] r_read_data, r_prog_data;

    logic              w_load_accept;
    logic              w_data_in_range, w_prog_in_range;
    logic              w_protect, w_data_commit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_load_accept   = (r_state == ST_LOAD) && load_valid;
    assign w_data_in_range = ({1'b0, address} < DEPTH_W);
    assign w_prog_in_range = ({1'b0, programAddress} < DEPTH_W);

`ifdef MEM_WRITE_PROTECT_EN
    assign w_protect = ({1'b0, address} < r_load_count);
`else
    assign w_protect = 1'b0;
`endif

    assign w_data_commit = (r_state == ST_RUN) && WE && w_data_in_range && !w_protect;

    // Single write port shared by the clear sweep, the image load and CPU data writes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_ptr;
        w_mem_wdata = '0;
        unique case (r_state)
            ST_CLEAR: w_mem_we = 1'b1;
            ST_LOAD: begin
                w_mem_we    = w_load_accept;
                w_mem_wdata = load_data;
            end
            ST_RUN: begin
                w_mem_we    = w_data_commit;
                w_mem_addr  = address;
                w_mem_wdata = writeData;
            end
            default: w_mem_we = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_ptr == LAST_PTR) w_state_next = ST_LOAD;
            ST_LOAD:  if (w_load_accept && (load_last || r_ptr == LAST_PTR)) w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_CLEAR;
            r_ptr        <= '0;
            r_load_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
            end else if (w_load_accept) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_load_count < DEPTH_W) r_load_count <= r_load_count + 1'b1;
            end
        end
    end

    // NOTE: the array has no reset; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

    // Both read ports forward a same-cycle committed write (write-first).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data <= '0;
            r_prog_data <= '0;
        end else if (r_state != ST_RUN) begin
            r_read_data <= '0;
            r_prog_data <= '0;
        end else begin
            if (!w_data_in_range)   r_read_data <= '0;
            else if (w_data_commit) r_read_data <= writeData;
            else                    r_read_data <= r_mem[address];

            if (!w_prog_in_range)                                r_prog_data <= '0;
            else if (w_data_commit && programAddress == address) r_prog_data <= writeData;
            else                                                 r_prog_data <= r_mem[programAddress];
        end
    end

`ifdef MEM_WRITE_PROTECT_EN
    logic r_prot_fault;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_prot_fault <= 1'b0;
        else if ((r_state == ST_RUN) && WE && w_protect) r_prot_fault <= 1'b1;
    end
    assign prot_fault = r_prot_fault;
`else
    assign prot_fault = 1'b0;
`endif

    assign load_ready  = (r_state == ST_LOAD);
    assign cpu_run     = (r_state == ST_RUN);
    assign load_count  = r_load_count;
    assign readData    = r_read_data;
    assign programData = r_prog_data;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; expectations follow MEM_WRITE_PROTECT_EN when defined.
module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1024;

`ifdef MEM_WRITE_PROTECT_EN
    localparam logic        PROT      = 1'b1;
`else
    localparam logic        PROT      = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              cpu_run;
    logic [ADDR_W:0]   load_count;
    logic [ADDR_W-1:0] programAddress;
    logic [DATA_W-1:0] programData;
    logic [ADDR_W-1:0] address;
    logic              WE;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              prot_fault;

    int n_total = 0;
    int n_bad   = 0;

    mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .cpu_run(cpu_run), .load_count(load_count),
        .programAddress(programAddress), .programData(programData),
        .address(address), .WE(WE), .writeData(writeData), .readData(readData),
        .prot_fault(prot_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!load_ready && n < 1100);
        check(tag, n, DEPTH);
    endtask

    task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        programAddress = '0; address = '0; WE = 1'b0; writeData = '0;

        #3;
        check("rst_load_ready", load_ready, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_load_count", load_count, 0);
        check("rst_read_data", readData, 0);
        check("rst_prog_data", programData, 0);
        check("rst_prot_fault", prot_fault, 0);
        #9 reset = 1'b1;
        wait_ready("clear_len_a");

        // WE during LOAD must be ignored; first word accepted in the same cycle.
        WE = 1'b1; address = 10'h050; writeData = 16'h9999;
        load_word(16'h1234, 1'b0);
        WE = 1'b0;
        check("load_read_zero", readData, 0);
        tick();
        check("load_cnt_gap", load_count, 1);
        load_word(16'hABCD, 1'b0);
        load_word(16'hF00F, 1'b1);
        check("run_cpu_run", cpu_run, 1);
        check("run_load_ready", load_ready, 0);
        check("run_load_count", load_count, 3);

        programAddress = 10'h001; address = 10'h050;
        tick();
        check("prog_word1", programData, 16'hABCD);
        check("we_in_load_dropped", readData, 0);

        load_valid = 1'b1; address = 10'h3FF; programAddress = 10'h000;
        tick();
        load_valid = 1'b0;
        check("clear_word_3ff", readData, 0);
        check("prog_word0", programData, 16'h1234);
        check("count_frozen", load_count, 3);

        WE = 1'b1; address = 10'h3FE; writeData = 16'h00AA;
        tick();
        WE = 1'b0;
        tick();
        check("wr_rd_3fe", readData, 16'h00AA);

        WE = 1'b1; address = 10'h100; writeData = 16'h5555;
        tick();
        check("write_first_100", readData, 16'h5555);

        address = 10'h200; writeData = 16'h7777; programAddress = 10'h200;
        tick();
        WE = 1'b0;
        check("prog_fwd_200", programData, 16'h7777);
        check("prot_clear", prot_fault, 0);

        WE = 1'b1; address = 10'h002; writeData = 16'hDEAD;
        tick();
        WE = 1'b0;
        check("prot_same_rd", readData, PROT ? 16'hF00F : 16'hDEAD);
        check("prot_set", prot_fault, PROT);
        tick();
        check("prot_word2", readData, PROT ? 16'hF00F : 16'hDEAD);
        WE = 1'b1; address = 10'h003; writeData = 16'hBEEF;
        tick();
        WE = 1'b0;
        tick();
        check("word3_commit", readData, 16'hBEEF);
        check("prot_sticky", prot_fault, PROT);

        // Second pass: reset mid-load must discard the partial image.
        #2 reset = 1'b0;
        #1;
        check("rst2_cpu_run", cpu_run, 0);
        check("rst2_prot", prot_fault, 0);
        check("rst2_read", readData, 0);
        #2 reset = 1'b1;
        wait_ready("clear_len_b");
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        check("partial_count", load_count, 2);
        #2 reset = 1'b0;
        #1;
        check("midload_count", load_count, 0);
        check("midload_ready", load_ready, 0);
        #2 reset = 1'b1;
        wait_ready("clear_len_c");
        load_word(16'h4321, 1'b1);
        check("rerun_cpu_run", cpu_run, 1);
        check("rerun_count", load_count, 1);

        address = 10'h3FE; programAddress = 10'h000;
        tick();
        check("recleared_3fe", readData, 0);
        check("rerun_word0", programData, 16'h4321);
        address = 10'h001; programAddress = 10'h200;
        tick();
        check("recleared_001", readData, 0);
        check("recleared_200", programData, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
